door_sensor_sequencer: RTL and testbench
========================================

Name: door_sensor_sequencer

Overview:
- Upstream stage of the customer counter. Turns two door photocells into single-cycle up/down pulses for the queue counter.
  - sensor_a is the outer beam; sensor_b is the inner beam.
- Synchronises and debounces both beams, then tracks the A→B (entry) and B→A (exit) crossing order in an FSM.
- Suppresses pulses the counter cannot accept (full/empty) and flags stalled or ambiguous crossings.

Parameters:
- DEBOUNCE, 4: consecutive cycles a synchronised beam must differ from its stable value before the stable value changes (≥1).
- TIMEOUT, 1000: cycles the FSM may remain in any single non-IDLE state before aborting (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sensor_a  input  1  raw outer photocell, 1 = beam broken, asynchronous to clk
- sensor_b  input  1  raw inner photocell, 1 = beam broken, asynchronous to clk
- full_flag  input  1  from counter; queue is full
- empty_flag  input  1  from counter; queue is empty
- up  output  1  one-cycle pulse: customer entered
- down  output  1  one-cycle pulse: customer left
- reject  output  1  one-cycle pulse: crossing completed but suppressed by full/empty
- fault  output  1  one-cycle pulse: timeout or ambiguous crossing
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset:
  - All synchroniser flops, stable values, debounce counters and the timeout counter clear to 0; FSM goes to IDLE.
  - up, down, reject, fault and busy are 0 in the cycle after reset is sampled high.
  - Reset mid-crossing discards the crossing with no pulse.
- Sync and debounce:
  - Each beam passes through a 2-flop synchroniser into a debounce counter.
  - The counter increments while the synchronised value ≠ stable and clears to 0 when they are equal.
  - When the count reaches DEBOUNCE, stable takes the synchronised value and the counter clears.
  - Net: a_st/b_st follow a clean raw edge exactly DEBOUNCE+2 cycles later. Glitches shorter than DEBOUNCE cycles never reach the FSM.
- FSM: states IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, CLEAR. All transitions evaluate (a_st, b_st).
  - IDLE:
    - 10 → IN1
    - 01 → OUT1
    - 11 → CLEAR, with fault pulse (both beams broken in the same cycle is ambiguous)
  - IN1: 11 → IN2; 00 → IDLE (backed out, no pulse); 01 → CLEAR + fault.
  - IN2: 01 → IN3; 10 → IN1; 00 → CLEAR + fault.
  - IN3:
    - 00 → IDLE with up=1 if full_flag=0, otherwise reject=1 and no up
    - 11 → IN2
    - 10 → CLEAR + fault
  - OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with a and b swapped.
    - OUT3 → IDLE on 00 produces down=1 if empty_flag=0, otherwise reject=1.
  - CLEAR: stays until 00, then → IDLE. No pulses are generated in CLEAR.
- Pulse timing:
  - up, down, reject and fault are registered. Each is high for exactly one cycle: the cycle after the clk edge that takes the transition.
  - At most one of up/down/reject is ever high in a given cycle.
  - full_flag and empty_flag are sampled in the same cycle as the completing transition.
- Timeout:
  - A counter of width $clog2(TIMEOUT+1) runs in every state except IDLE and CLEAR, and clears on every state change.
  - When it reaches TIMEOUT: fault pulse, FSM → CLEAR.
  - A person standing in the doorway therefore produces exactly one fault, then a silent recovery.
- busy = (state ≠ IDLE), registered with the state.
- Sustained pulse rate is at most one up/down per crossing. Back-to-back entries need the FSM to return through IDLE.

Test Plan:
- Clean entry (DEBOUNCE=4, full_flag=0):
  - Stimulus: a rises; 20 cycles later b rises; 20 later a falls; 20 later b falls.
  - Required: exactly one up pulse, 1 cycle wide, 7 cycles after the b fall (6 sync/debounce + 1 registered); down=reject=fault=0 throughout.
- Clean exit with empty_flag=1:
  - Stimulus: b→a crossing order.
  - Required: one reject pulse, no down. Repeat with empty_flag=0 → one down pulse.
- Bounce rejection:
  - Stimulus: 3-cycle pulses on sensor_a repeated 10 times, 2 cycles apart.
  - Required: a_st never changes, busy stays 0, no outputs.
- Backout:
  - Stimulus: a rises, b rises, b falls, a falls.
  - Required: FSM goes IN1→IN2→IN1→IDLE; no pulses of any kind.
- Timeout (TIMEOUT=50):
  - Stimulus: a held high indefinitely.
  - Required: exactly one fault pulse 50 cycles after entering IN1, busy stays 1 in CLEAR. Releasing a → IDLE, busy=0, no further pulses.
- Simultaneous beams and mid-crossing reset:
  - Stimulus: a and b rise on the same edge.
  - Required: one fault, CLEAR until both low.
  - Stimulus: separately, assert reset while in IN2.
  - Required: next cycle all outputs 0, state IDLE; completing the crossing afterwards yields no up.

Source files
------------

// File: rtl/door_sensor_sequencer_if.sv
// door_sensor_sequencer_if: photocell inputs, counter flags and crossing pulses between door front end and sequencer
interface door_sensor_sequencer_if;
    logic sensor_a;
    logic sensor_b;
    logic full_flag;
    logic empty_flag;
    logic up;
    logic down;
    logic reject;
    logic fault;
    logic busy;
    modport master (
        output sensor_a, sensor_b, full_flag, empty_flag,
        input  up, down, reject, fault, busy
    );
    modport slave (
        input  sensor_a, sensor_b, full_flag, empty_flag,
        output up, down, reject, fault, busy
    );
endinterface

// File: rtl/door_sensor_sequencer.sv
// door_sensor_sequencer: debounces two door beams and turns A->B / B->A crossings into up/down/reject/fault pulses
module door_sensor_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000
) (
    input logic clk,
    input logic reset,
    door_sensor_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, CLEAR} state_t;
    state_t state, nxt;
    logic [1:0] sync_a, sync_b, ab;
    logic a_st, b_st;
    logic [DW-1:0] cnt_a, cnt_b;
    logic [TW-1:0] tmr;
    logic expire, done_in, done_out, up_d, down_d, reject_d, fault_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            a_st <= 1'b0;
            b_st <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            sync_a <= {sync_a[0], bus.sensor_a};
            sync_b <= {sync_b[0], bus.sensor_b};
            cnt_a <= (sync_a[1] == a_st || cnt_a == DW'(DEBOUNCE - 1)) ? '0 : cnt_a + 1'b1;
            cnt_b <= (sync_b[1] == b_st || cnt_b == DW'(DEBOUNCE - 1)) ? '0 : cnt_b + 1'b1;
            a_st <= (sync_a[1] != a_st && cnt_a == DW'(DEBOUNCE - 1)) ? sync_a[1] : a_st;
            b_st <= (sync_b[1] != b_st && cnt_b == DW'(DEBOUNCE - 1)) ? sync_b[1] : b_st;
        end
    end
    assign ab = {a_st, b_st};
    assign expire = state != IDLE && state != CLEAR && tmr == TW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tmr <= '0;
            bus.up <= 1'b0;
            bus.down <= 1'b0;
            bus.reject <= 1'b0;
            bus.fault <= 1'b0;
        end else begin
            state <= nxt;
            tmr <= (nxt == state && state != IDLE && state != CLEAR) ? tmr + 1'b1 : '0;
            bus.up <= up_d;
            bus.down <= down_d;
            bus.reject <= reject_d;
            bus.fault <= fault_d;
        end
    end
    assign bus.busy = state != IDLE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = ab == 2'b10 ? IN1  : ab == 2'b01 ? OUT1 : ab == 2'b11 ? CLEAR : IDLE;
            IN1:   nxt = ab == 2'b11 ? IN2  : ab == 2'b00 ? IDLE : ab == 2'b01 ? CLEAR : IN1;
            IN2:   nxt = ab == 2'b01 ? IN3  : ab == 2'b10 ? IN1  : ab == 2'b00 ? CLEAR : IN2;
            IN3:   nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? IN2  : ab == 2'b10 ? CLEAR : IN3;
            OUT1:  nxt = ab == 2'b11 ? OUT2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? CLEAR : OUT1;
            OUT2:  nxt = ab == 2'b10 ? OUT3 : ab == 2'b01 ? OUT1 : ab == 2'b00 ? CLEAR : OUT2;
            OUT3:  nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? OUT2 : ab == 2'b01 ? CLEAR : OUT3;
            CLEAR: nxt = ab == 2'b00 ? IDLE : CLEAR;
        endcase
        if (nxt == state && expire) nxt = CLEAR;
    end
    always_comb begin
        done_in = state == IN3 && nxt == IDLE;
        done_out = state == OUT3 && nxt == IDLE;
        up_d = done_in && !bus.full_flag;
        down_d = done_out && !bus.empty_flag;
        reject_d = (done_in && bus.full_flag) || (done_out && bus.empty_flag);
        fault_d = nxt == CLEAR && state != CLEAR;
    end
endmodule

// File: tb/tb_door_sensor_sequencer.sv
// tb_door_sensor_sequencer: table, directed and randomized checks of the door sequencer against a crossing-position model
module tb_door_sensor_sequencer;
    localparam int DB = 4;
    localparam int TO = 50;
    logic clk = 1'b0;
    logic reset = 1'b1;
    door_sensor_sequencer_if bus();
    door_sensor_sequencer #(.DEBOUNCE(DB), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {int a; int b; int full; int empty; int up; int dn; int rj; int ft; int busy;} vec_t;
    vec_t tbl [23];
    int n_chk = 0;
    int n_pass = 0;
    int cnt_up = 0, cnt_down = 0, cnt_rej = 0, cnt_fault = 0, cnt_busy = 0;
    bit hist_a[$], hist_b[$];
    int edge_n = -1, base = -1, pos = 0, hold = 0;
    bit st_a, st_b, clr, started;
    bit e_up, e_down, e_rej, e_fault, e_busy;
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    function automatic logic [1:0] gray(input int p);
        int i = ((p % 4) + 4) % 4;
        return i == 0 ? 2'b00 : i == 1 ? 2'b10 : i == 2 ? 2'b11 : 2'b01;
    endfunction
    function automatic bit raw_at(input bit sel, input int k);
        if (k <= base || k < 0) return 1'b0;
        return sel ? hist_b[k] : hist_a[k];
    endfunction
    always @(posedge clk) begin
        logic [1:0] ab;
        bit fa, fb;
        edge_n++;
        hist_a.push_back(bus.sensor_a);
        hist_b.push_back(bus.sensor_b);
        {e_up, e_down, e_rej, e_fault} = '0;
        if (reset) begin
            base = edge_n;
            st_a = 1'b0;
            st_b = 1'b0;
            pos = 0;
            clr = 1'b0;
            hold = 0;
            started = 1'b1;
        end else begin
            ab = {st_a, st_b};
            if (clr) clr = ab != 2'b00;
            else if ($countones(ab ^ gray(pos)) == 2) begin
                e_fault = 1'b1;
                clr = 1'b1;
                pos = 0;
                hold = 0;
            end else if (ab != gray(pos)) begin
                pos = gray(pos + 1) == ab ? pos + 1 : pos - 1;
                hold = 0;
                if (pos == 4) begin
                    pos = 0;
                    e_up = !bus.full_flag;
                    e_rej = bus.full_flag;
                end else if (pos == -4) begin
                    pos = 0;
                    e_down = !bus.empty_flag;
                    e_rej = bus.empty_flag;
                end
            end else if (pos != 0) begin
                hold++;
                if (hold == TO) begin
                    e_fault = 1'b1;
                    clr = 1'b1;
                    pos = 0;
                    hold = 0;
                end
            end
            fa = 1'b1;
            fb = 1'b1;
            for (int k = edge_n - DB - 1; k <= edge_n - 2; k++) begin
                if (raw_at(1'b0, k) == st_a) fa = 1'b0;
                if (raw_at(1'b1, k) == st_b) fb = 1'b0;
            end
            st_a ^= fa;
            st_b ^= fb;
        end
        e_busy = clr || pos != 0;
        #1;
        if (started) begin
            n_chk++;
            if ({bus.up, bus.down, bus.reject, bus.fault, bus.busy} === {e_up, e_down, e_rej, e_fault, e_busy}) n_pass++;
            else $display("FAIL cycle %0d up/down/reject/fault/busy: got %b, expected %b", edge_n,
                          {bus.up, bus.down, bus.reject, bus.fault, bus.busy}, {e_up, e_down, e_rej, e_fault, e_busy});
            cnt_up += int'(bus.up);
            cnt_down += int'(bus.down);
            cnt_rej += int'(bus.reject);
            cnt_fault += int'(bus.fault);
            cnt_busy += int'(bus.busy);
        end
    end
    task automatic drive(input int a, input int b, input int n);
        @(negedge clk);
        bus.sensor_a = a[0];
        bus.sensor_b = b[0];
        repeat (n) @(posedge clk);
    endtask
    task automatic run_vec(input vec_t v, input int i);
        int u = cnt_up, d = cnt_down, r = cnt_rej, f = cnt_fault;
        @(negedge clk);
        bus.full_flag = v.full[0];
        bus.empty_flag = v.empty[0];
        drive(v.a, v.b, 20);
        #2;
        check($sformatf("row%0d up", i), cnt_up - u, v.up);
        check($sformatf("row%0d down", i), cnt_down - d, v.dn);
        check($sformatf("row%0d reject", i), cnt_rej - r, v.rj);
        check($sformatf("row%0d fault", i), cnt_fault - f, v.ft);
        check($sformatf("row%0d busy", i), int'(bus.busy), v.busy);
    endtask
    task automatic clean_entry_timing();
        int d = cnt_down, r = cnt_rej, f = cnt_fault;
        drive(1, 0, 20);
        drive(1, 1, 20);
        drive(0, 1, 20);
        @(negedge clk);
        bus.sensor_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("entry up at +%0d", i), int'(bus.up), i == 7 ? 1 : 0);
        end
        check("entry other pulses", (cnt_down - d) + (cnt_rej - r) + (cnt_fault - f), 0);
    endtask
    task automatic bounce();
        int u = cnt_up + cnt_down + cnt_rej + cnt_fault, bz = cnt_busy;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            bus.sensor_a = 1'b1;
            repeat (3) @(negedge clk);
            bus.sensor_a = 1'b0;
            @(negedge clk);
        end
        repeat (12) @(posedge clk);
        #2;
        check("bounce busy cycles", cnt_busy - bz, 0);
        check("bounce pulses", cnt_up + cnt_down + cnt_rej + cnt_fault - u, 0);
    endtask
    task automatic timeout_run();
        int busy_at = -1, fault_at = -1, nf = 0, u;
        @(negedge clk);
        bus.sensor_a = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            #2;
            if (busy_at < 0 && bus.busy) busy_at = i;
            if (bus.fault) begin
                nf++;
                if (fault_at < 0) fault_at = i;
            end
        end
        check("timeout busy edge", busy_at, 7);
        check("timeout fault count", nf, 1);
        check("timeout fault delay", fault_at - busy_at, TO);
        check("timeout busy in clear", int'(bus.busy), 1);
        u = cnt_up + cnt_down + cnt_rej + cnt_fault;
        drive(0, 0, 12);
        #2;
        check("timeout recovered busy", int'(bus.busy), 0);
        check("timeout recovery pulses", cnt_up + cnt_down + cnt_rej + cnt_fault - u, 0);
    endtask
    task automatic mid_reset();
        int u;
        drive(1, 0, 20);
        drive(1, 1, 20);
        #2;
        check("midreset busy before", int'(bus.busy), 1);
        @(negedge clk);
        reset = 1'b1;
        bus.sensor_a = 1'b0;
        @(posedge clk);
        #2;
        check("midreset outputs", int'({bus.up, bus.down, bus.reject, bus.fault, bus.busy}), 0);
        u = cnt_up + cnt_down + cnt_rej + cnt_fault;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        drive(0, 0, 20);
        #2;
        check("midreset no pulses after", cnt_up + cnt_down + cnt_rej + cnt_fault - u, 0);
        check("midreset idle after", int'(bus.busy), 0);
    endtask
    task automatic random_run();
        logic [1:0] pat = 2'b00;
        int hold_n;
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 3) != 0) pat[$urandom_range(0, 1)] ^= 1'b1;
            else pat = 2'($urandom_range(0, 3));
            bus.sensor_a = pat[1];
            bus.sensor_b = pat[0];
            bus.full_flag = 1'($urandom_range(0, 1));
            bus.empty_flag = 1'($urandom_range(0, 1));
            hold_n = $urandom_range(0, 9) == 0 ? $urandom_range(50, 70) : $urandom_range(1, 25);
            repeat (hold_n - 1) @(negedge clk);
        end
        drive(0, 0, 80);
    endtask
    initial begin
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        bus.full_flag = 1'b0;
        bus.empty_flag = 1'b0;
        tbl = '{
            '{1,0,0,0, 0,0,0,0,1}, '{1,1,0,0, 0,0,0,0,1}, '{0,1,0,0, 0,0,0,0,1}, '{0,0,0,0, 1,0,0,0,0},
            '{0,1,0,1, 0,0,0,0,1}, '{1,1,0,1, 0,0,0,0,1}, '{1,0,0,1, 0,0,0,0,1}, '{0,0,0,1, 0,0,1,0,0},
            '{0,1,0,0, 0,0,0,0,1}, '{1,1,0,0, 0,0,0,0,1}, '{1,0,0,0, 0,0,0,0,1}, '{0,0,0,0, 0,1,0,0,0},
            '{1,0,1,0, 0,0,0,0,1}, '{1,1,1,0, 0,0,0,0,1}, '{0,1,1,0, 0,0,0,0,1}, '{0,0,1,0, 0,0,1,0,0},
            '{1,0,0,0, 0,0,0,0,1}, '{1,1,0,0, 0,0,0,0,1}, '{1,0,0,0, 0,0,0,0,1}, '{0,0,0,0, 0,0,0,0,0},
            '{1,1,0,0, 0,0,0,1,1}, '{0,1,0,0, 0,0,0,0,1}, '{0,0,0,0, 0,0,0,0,0}
        };
        repeat (3) @(posedge clk);
        #2;
        check("reset outputs", int'({bus.up, bus.down, bus.reject, bus.fault, bus.busy}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        foreach (tbl[i]) run_vec(tbl[i], i);
        @(negedge clk);
        bus.full_flag = 1'b0;
        bus.empty_flag = 1'b0;
        clean_entry_timing();
        bounce();
        timeout_run();
        mid_reset();
        random_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
